sample_delay_ram: RTL and testbench

SAMPLE_DELAY_RAM -- requirements
Module: sample_delay_ram

---
 rtl/sample_delay_ram.sv | 90 +++++++++
 tb/tb_sample_delay_ram.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_delay_ram.sv
// Strobe-counted delay line: a circular sample buffer with a registered,
// offset-addressed read and a fill tracker that flags when dout is a genuine delayed sample.
module sample_delay_ram #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic                     full
);

    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] FILL_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] fill;
    logic [ADDRESS_WIDTH-1:0] fill_next;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic                     strobe;
    logic [DATA_WIDTH-1:0]    ram [DEPTH];

    assign strobe  = en & ~clr;
    assign rd_addr = wr_addr - offset;
    assign full    = (state == FULL);

    // Storage carries no reset; only the pointers and flags restart.
    always_ff @(posedge clk) begin
        if (strobe) begin
            ram[wr_addr] <= din;
        end
    end

    always_comb begin
        fill_next  = fill;
        state_next = state;
        if (clr) begin
            fill_next  = '0;
            state_next = EMPTY;
        end else if (en) begin
            if (fill != FILL_MAX) begin
                fill_next = fill + 1'b1;
            end
            case (state)
                EMPTY:   state_next = (fill_next == FILL_MAX) ? FULL : FILLING;
                FILLING: state_next = (fill_next == FILL_MAX) ? FULL : FILLING;
                FULL:    state_next = FULL;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            fill       <= '0;
            wr_addr    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            state <= state_next;
            fill  <= fill_next;
            if (clr) begin
                wr_addr    <= '0;
                dout_valid <= 1'b0;
            end else if (en) begin
                wr_addr    <= wr_addr + 1'b1;
                // Zero delay forwards din; the array slot is only written this edge.
                dout       <= (offset == '0) ? din : ram[rd_addr];
                dout_valid <= (fill >= offset);
            end else begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_delay_ram.sv
// Bench for sample_delay_ram: per-cycle comparison against a strobe-history model,
// plus directed literal checks on hand-computed vectors.
module tb_sample_delay_ram;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned FMAX = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW-1:0] offset = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [AW-1:0] wr_addr;
    logic          full;

    int compared = 0;
    int mismatched = 0;

    sample_delay_ram #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .clr(clr),
        .din(din),
        .offset(offset),
        .dout(dout),
        .dout_valid(dout_valid),
        .wr_addr(wr_addr),
        .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: k counts accepted strobes since reset/clr; hist[k] is strobe k's sample.
    logic [DW-1:0] hist[$];
    int            k = 0;
    logic          e_valid = 1'b0;
    logic [DW-1:0] e_dout = '0;
    logic          e_known = 1'b1;

    always @(posedge clk) begin
        logic          s_rst, s_en, s_clr;
        logic [DW-1:0] s_din;
        int            s_off;
        int            fill_sat;
        s_rst = rst; s_en = en; s_clr = clr; s_din = din; s_off = int'(offset);
        if (s_rst) begin
            k = 0; hist.delete(); e_valid = 1'b0; e_dout = '0; e_known = 1'b1;
        end else if (s_clr) begin
            k = 0; hist.delete(); e_valid = 1'b0;
        end else if (s_en) begin
            fill_sat = (k > int'(FMAX)) ? int'(FMAX) : k;
            e_valid = (fill_sat >= s_off);
            if (s_off == 0) begin
                e_dout = s_din; e_known = 1'b1;
            end else if (k >= s_off) begin
                e_dout = hist[k - s_off]; e_known = 1'b1;
            end else begin
                e_known = 1'b0;
            end
            hist.push_back(s_din);
            k++;
        end else begin
            e_valid = 1'b0;
        end
        #1;
        check("model_dout_valid", 32'(dout_valid), 32'(e_valid));
        check("model_full", 32'(full), 32'(k >= int'(FMAX)));
        check("model_wr_addr", 32'(wr_addr), 32'(k % (1 << AW)));
        if (e_known) check("model_dout", 32'(dout), 32'(e_dout));
    end

    // One clock: apply inputs at negedge, return 2 time units after the posedge.
    task automatic cyc(input logic e, input logic c, input logic [DW-1:0] d);
        @(negedge clk);
        en = e; clr = c; din = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        @(posedge clk);
        #2;
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_valid", 32'(dout_valid), 32'h0);
        check("reset_wr_addr", 32'(wr_addr), 32'h0);
        check("reset_full", 32'(full), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Zero offset forwards din with one edge of latency
        offset = 4'd0;
        cyc(1'b1, 1'b0, 8'h11);
        check("fwd_dout0", 32'(dout), 32'h11);
        check("fwd_valid0", 32'(dout_valid), 32'h1);
        cyc(1'b1, 1'b0, 8'h22);
        check("fwd_dout1", 32'(dout), 32'h22);
        check("fwd_valid1", 32'(dout_valid), 32'h1);

        cyc(1'b0, 1'b1, 8'h00);
        offset = 4'd3;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 8'(i + 1));
            if (i < 3) begin
                check("off3_valid_low", 32'(dout_valid), 32'h0);
            end else begin
                check("off3_dout", 32'(dout), 32'(i - 2));
                check("off3_valid", 32'(dout_valid), 32'h1);
            end
        end

        // Maximum offset, wrap of wr_addr and fill saturation
        cyc(1'b0, 1'b1, 8'h00);
        offset = 4'd15;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            if (i == 13) check("wrap_full_low", 32'(full), 32'h0);
            if (i == 14) begin
                check("wrap_full_high", 32'(full), 32'h1);
                check("wrap_valid14", 32'(dout_valid), 32'h0);
                check("wrap_addr14", 32'(wr_addr), 32'hF);
            end
            if (i == 15) begin
                check("wrap_dout15", 32'(dout), 32'h0);
                check("wrap_valid15", 32'(dout_valid), 32'h1);
                check("wrap_addr15", 32'(wr_addr), 32'h0);
            end
            if (i == 19) check("wrap_dout19", 32'(dout), 32'h4);
        end

        // Gaps between strobes: delay counts strobes, dout holds in gaps
        cyc(1'b0, 1'b1, 8'h00);
        check("clr_full", 32'(full), 32'h0);
        offset = 4'd2;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 8'hA0 + 8'(i));
            if (i >= 2) check("gap_dout", 32'(dout), 32'hA0 + 32'(i - 2));
            for (int g = 0; g < 3; g++) begin
                cyc(1'b0, 1'b0, 8'hEE);
                check("gap_valid_low", 32'(dout_valid), 32'h0);
                if (i >= 2) check("gap_hold", 32'(dout), 32'hA0 + 32'(i - 2));
            end
        end

        // clr beats a simultaneous strobe
        cyc(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'h30 + 8'(i));
        cyc(1'b1, 1'b1, 8'h55);
        check("clr_wr_addr", 32'(wr_addr), 32'h0);
        check("clr_full2", 32'(full), 32'h0);
        check("clr_valid", 32'(dout_valid), 32'h0);
        cyc(1'b1, 1'b0, 8'h60);
        check("post_clr_v0", 32'(dout_valid), 32'h0);
        cyc(1'b1, 1'b0, 8'h61);
        check("post_clr_v1", 32'(dout_valid), 32'h0);
        cyc(1'b1, 1'b0, 8'h62);
        check("post_clr_dout", 32'(dout), 32'h60);
        check("post_clr_v2", 32'(dout_valid), 32'h1);

        // Raising offset above fill drops dout_valid
        offset = 4'd10;
        cyc(1'b1, 1'b0, 8'h63);
        check("offset_raise_valid", 32'(dout_valid), 32'h0);
        offset = 4'd1;
        cyc(1'b1, 1'b0, 8'h64);
        check("offset_lower_dout", 32'(dout), 32'h63);
        check("offset_lower_valid", 32'(dout_valid), 32'h1);

        // Asynchronous reset between edges, held across an edge with en high
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_dout", 32'(dout), 32'h0);
        check("arst_valid", 32'(dout_valid), 32'h0);
        check("arst_wr_addr", 32'(wr_addr), 32'h0);
        check("arst_full", 32'(full), 32'h0);
        en = 1'b1; din = 8'h77;
        @(posedge clk);
        #2;
        check("arst_no_strobe", 32'(wr_addr), 32'h0);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        offset = 4'd0;
        cyc(1'b1, 1'b0, 8'h11);
        check("after_rst_dout", 32'(dout), 32'h11);
        check("after_rst_valid", 32'(dout_valid), 32'h1);
        check("after_rst_addr", 32'(wr_addr), 32'h1);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
